// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding, store defaults and accumulator width helper
package matmul_pkg;

  localparam int M_DEF  = 2;
  localparam int K_DEF  = 2;
  localparam int N_DEF  = 2;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Full product plus enough headroom for K additions, so the sum never wraps.
  function automatic int acc_w(input int dw, input int k);
    return 2 * dw + $clog2(k) + 1;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// rtl/mac_unit.sv - unsigned multiply-accumulate; clear loads the product, otherwise it is added
module mac_unit
  import matmul_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int K  = K_DEF,
  parameter int AW = acc_w(DW, K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          clear,
  input  logic          en,
  output logic [AW-1:0] acc
);

  logic [2*DW-1:0] mul;
  logic [AW-1:0]   prod;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   acc_d;

  assign mul  = a * b;
  assign prod = {{(AW - 2*DW){1'b0}}, mul};

  always_comb begin
    acc_d = acc_q;
    if (en) begin
      acc_d = clear ? prod : acc_q + prod;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - walks i/j/k over A, B and C stores, accumulates and writes C[i][j]
// SATURATE_EN: clamp written results to 2^DW-1 and expose a sticky ovf flag.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int M  = M_DEF,
  parameter int K  = K_DEF,
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] aRowSel,
  output logic [DW-1:0] aColSel,
  input  logic [DW-1:0] aData,
  output logic [DW-1:0] bRowSel,
  output logic [DW-1:0] bColSel,
  input  logic [DW-1:0] bData,
  output logic          cWriteEn,
  output logic [DW-1:0] cRowSel,
  output logic [DW-1:0] cColSel,
  output logic [DW-1:0] cData
`ifdef SATURATE_EN
  ,
  output logic          ovf
`endif
);

  localparam int AW = acc_w(DW, K);
  localparam logic [DW-1:0] M_LAST = DW'(M - 1);
  localparam logic [DW-1:0] K_LAST = DW'(K - 1);
  localparam logic [DW-1:0] N_LAST = DW'(N - 1);

  state_t        state_q;
  logic [DW-1:0] i_q, j_q, k_q;
  logic          busy_q, done_q, cwe_q;
  logic [AW-1:0] acc;
  logic [DW-1:0] result;

  mac_unit #(.DW(DW), .K(K), .AW(AW)) u_mac (
    .clk  (clk),
    .rst  (rst),
    .a    (aData),
    .b    (bData),
    .clear(k_q == '0),
    .en   (state_q == ST_MAC),
    .acc  (acc)
  );

`ifdef SATURATE_EN
  logic sat_hit;
  logic ovf_q;
  assign sat_hit = |acc[AW-1:DW];
  assign result  = sat_hit ? {DW{1'b1}} : acc[DW-1:0];
  assign ovf     = ovf_q;
`else
  logic unused_acc_hi;
  assign result        = acc[DW-1:0];
  assign unused_acc_hi = ^acc[AW-1:DW];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cwe_q   <= 1'b0;
`ifdef SATURATE_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      cwe_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_MAC;
            busy_q  <= 1'b1;
`ifdef SATURATE_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        ST_MAC: begin
          if (k_q == K_LAST) begin
            k_q     <= '0;
            state_q <= ST_WRITE;
            cwe_q   <= 1'b1;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        ST_WRITE: begin
`ifdef SATURATE_EN
          if (sat_hit) ovf_q <= 1'b1;
`endif
          // Indices return to zero on the last element so Sel outputs read 0 in DONE.
          if (i_q == M_LAST && j_q == N_LAST) begin
            i_q     <= '0;
            j_q     <= '0;
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_MAC;
            if (j_q == N_LAST) begin
              j_q <= '0;
              i_q <= i_q + 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign cWriteEn = cwe_q;
  assign cData    = cwe_q ? result : '0;
  assign aRowSel  = i_q;
  assign aColSel  = k_q;
  assign bRowSel  = k_q;
  assign bColSel  = j_q;
  assign cRowSel  = i_q;
  assign cColSel  = j_q;

endmodule
